// File: rtl/micro_sequencer.sv
// Micro-program sequencer: holds the micro-PC feeding the microcode ROM, picks
// sequential or branch successors, and handshakes start/stall/halt with the host.
//
// state | meaning
// IDLE  | waiting for start; micro-PC parked at START_ADDR
// RUN   | ROM word at reg_out executes; PC advances unless halted or stalled
// WAIT  | datapath busy; current instruction held for re-issue
// DONE  | one-cycle completion pulse, then back to IDLE
module micro_sequencer #(
    parameter int PC_W       = 16,
    parameter int JADDR_W    = 7,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               stall,
    input  logic               halt,
    input  logic               z_flag,
    input  logic               core_done,
    input  logic [1:0]         condition,
    input  logic               BT,
    input  logic [JADDR_W-1:0] jump_addr,
    output logic [PC_W-1:0]    reg_out,
    output logic               run,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [PC_W-1:0]  PC_START = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state;
    state_t            state_nxt;
    logic              cond_true;
    logic [PC_W-1:0]   next_pc;
    logic [CNT_W-1:0]  retired_inc;

    always_comb begin
        cond_true = 1'b1;
        case (condition)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = z_flag;
            2'b10:   cond_true = ~z_flag;
            default: cond_true = core_done;
        endcase
    end

    // Branch targets are zero-extended; sequential successor wraps naturally.
    assign next_pc     = (BT && cond_true) ? PC_W'(jump_addr) : reg_out + PC_W'(1);
    assign retired_inc = (retired == CNT_MAX) ? retired : retired + CNT_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (halt)       state_nxt = S_DONE;
                else if (stall) state_nxt = S_WAIT;
                else            state_nxt = S_RUN;
            end
            S_WAIT: if (!stall) state_nxt = S_RUN;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reg_out <= PC_START;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    reg_out <= PC_START;
                    if (start) retired <= '0;
                end
                S_RUN: begin
                    if (halt) begin
                        retired <= retired_inc;
                    end else if (!stall) begin
                        reg_out <= next_pc;
                        retired <= retired_inc;
                    end
                end
                S_DONE: reg_out <= PC_START;
                default: ;
            endcase
        end
    end

    always_comb begin
        run  = (state == S_RUN);
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a full-size instance plus a narrow one
// (7-bit PC, 3-bit counter) for the wrap and saturation boundaries.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, stall, halt, z_flag, core_done, BT;
    logic [1:0]  condition;
    logic [6:0]  jump_addr;
    logic [15:0] reg_out;
    logic        run, busy, done;
    logic [15:0] retired;
    logic [6:0]  s_reg_out;
    logic        s_run, s_busy, s_done;
    logic [2:0]  s_retired;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk(clk), .rstn(rstn), .start(start), .stall(stall), .halt(halt),
        .z_flag(z_flag), .core_done(core_done), .condition(condition), .BT(BT),
        .jump_addr(jump_addr), .reg_out(reg_out), .run(run), .busy(busy),
        .done(done), .retired(retired)
    );

    micro_sequencer #(.PC_W(7), .JADDR_W(7), .START_ADDR(0), .CNT_W(3)) dut_s (
        .clk(clk), .rstn(rstn), .start(start), .stall(stall), .halt(halt),
        .z_flag(z_flag), .core_done(core_done), .condition(condition), .BT(BT),
        .jump_addr(jump_addr), .reg_out(s_reg_out), .run(s_run), .busy(s_busy),
        .done(s_done), .retired(s_retired)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_prog();
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (reg_out !== 16'd0 || run !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || retired !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: reg_out=%0d run=%b busy=%b done=%b retired=%0d, want 0/0/0/0/0",
                         i, reg_out, run, busy, done, retired);
            end
        end
    endtask

    task automatic test_sequential();
        launch();
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (reg_out !== 16'(i) || run !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_pc%0d: reg_out=%0d run=%b, want %0d run=1", i, reg_out, run, i);
            end
            step();
        end
        n_tests++;
        if (reg_out !== 16'd6) begin
            n_fail++;
            $display("FAIL seq_pc6: reg_out=%0d, want 6", reg_out);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_tests++;
        if (done !== 1'b1 || run !== 1'b0 || busy !== 1'b1 || reg_out !== 16'd6) begin
            n_fail++;
            $display("FAIL seq_done: done=%b run=%b busy=%b reg_out=%0d, want 1/0/1/6", done, run, busy, reg_out);
        end
        step();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || reg_out !== 16'd0 || retired !== 16'd7) begin
            n_fail++;
            $display("FAIL seq_idle: done=%b busy=%b reg_out=%0d retired=%0d, want 0/0/0/7", done, busy, reg_out, retired);
        end
    endtask

    task automatic test_branch();
        logic [1:0]  c_cond [6] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11};
        logic        c_z    [6] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
        logic        c_cd   [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
        logic [15:0] c_exp  [6] = '{16'd40, 16'd4, 16'd40, 16'd40, 16'd40, 16'd4};
        for (int k = 0; k < 6; k++) begin
            launch();
            step();
            step();
            step();
            BT = 1'b1; condition = c_cond[k]; jump_addr = 7'd40;
            z_flag = c_z[k]; core_done = c_cd[k];
            step();
            BT = 1'b0; condition = 2'b00; z_flag = 1'b0; core_done = 1'b0;
            n_tests++;
            if (reg_out !== c_exp[k]) begin
                n_fail++;
                $display("FAIL branch_case%0d: reg_out=%0d, want %0d", k, reg_out, c_exp[k]);
            end
            finish_prog();
        end
    endtask

    task automatic test_stall();
        launch();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            halt = (i == 1);
            step();
            n_tests++;
            if (reg_out !== 16'd2 || run !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || retired !== 16'd2) begin
                n_fail++;
                $display("FAIL stall_cyc%0d: reg_out=%0d run=%b busy=%b done=%b retired=%0d, want 2/0/1/0/2",
                         i, reg_out, run, busy, done, retired);
            end
        end
        halt = 1'b0;
        stall = 1'b0;
        step();
        n_tests++;
        if (reg_out !== 16'd2 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_reissue: reg_out=%0d run=%b, want 2 run=1", reg_out, run);
        end
        step();
        n_tests++;
        if (reg_out !== 16'd3 || retired !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_resume: reg_out=%0d retired=%0d, want 3/3", reg_out, retired);
        end
        finish_prog();
    endtask

    task automatic test_priority();
        launch();
        for (int i = 0; i < 5; i++) step();
        halt = 1'b1;
        stall = 1'b1;
        step();
        halt = 1'b0;
        stall = 1'b0;
        n_tests++;
        if (done !== 1'b1 || reg_out !== 16'd5 || retired !== 16'd6) begin
            n_fail++;
            $display("FAIL halt_over_stall: done=%b reg_out=%0d retired=%0d, want 1/5/6", done, reg_out, retired);
        end
        step();
    endtask

    task automatic test_wrap_saturate();
        launch();
        BT = 1'b1; condition = 2'b00; jump_addr = 7'd127;
        step();
        BT = 1'b0;
        n_tests++;
        if (reg_out !== 16'd127 || s_reg_out !== 7'd127) begin
            n_fail++;
            $display("FAIL wrap_jump: reg_out=%0d small=%0d, want 127/127", reg_out, s_reg_out);
        end
        step();
        n_tests++;
        if (reg_out !== 16'd128 || s_reg_out !== 7'd0 || s_retired !== 3'd2) begin
            n_fail++;
            $display("FAIL wrap_pc: reg_out=%0d small=%0d small_retired=%0d, want 128/0/2", reg_out, s_reg_out, s_retired);
        end
        for (int i = 0; i < 8; i++) step();
        n_tests++;
        if (retired !== 16'd10 || s_retired !== 3'd7) begin
            n_fail++;
            $display("FAIL saturate: retired=%0d small_retired=%0d, want 10/7", retired, s_retired);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_tests++;
        if (retired !== 16'd11 || s_retired !== 3'd7 || s_done !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_halt: retired=%0d small_retired=%0d small_done=%b, want 11/7/1", retired, s_retired, s_done);
        end
        step();
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b, want 1", done);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || reg_out !== 16'd0 || retired !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b reg_out=%0d retired=%0d, want 0/0/1", busy, reg_out, retired);
        end
        step();
        start = 1'b0;
        n_tests++;
        if (run !== 1'b1 || retired !== 16'd0 || reg_out !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_relaunch: run=%b retired=%0d reg_out=%0d, want 1/0/0", run, retired, reg_out);
        end
        finish_prog();
    endtask

    task automatic test_async_reset();
        launch();
        for (int i = 0; i < 4; i++) step();
        n_tests++;
        if (reg_out !== 16'd4 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: reg_out=%0d run=%b, want 4/1", reg_out, run);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (reg_out !== 16'd0 || run !== 1'b0 || busy !== 1'b0 || retired !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_now: reg_out=%0d run=%b busy=%b retired=%0d, want 0/0/0/0", reg_out, run, busy, retired);
        end
        #10;
        rstn = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || reg_out !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_idle: busy=%b reg_out=%0d, want 0/0", busy, reg_out);
        end
    endtask

    initial begin
        start = 1'b0; stall = 1'b0; halt = 1'b0; z_flag = 1'b0; core_done = 1'b0;
        BT = 1'b0; condition = 2'b00; jump_addr = 7'd0; rstn = 1'b1;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_priority();
        test_wrap_saturate();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
